// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: data/register-file geometry and the
// writeback arbiter state encoding.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic {
    ARB_CLEAR,
    ARB_RUN
  } arb_state_e;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback requester bus: per-requester valid/ready with packed addr/data slices.
interface regfile_wr_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps at NREQ-1;
// outputs a one-hot (or zero) grant and the granted index.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [2:0]      ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [2:0]      idx_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    // Priority distance k from the pointer; first valid requester at the smallest k wins.
    for (int unsigned k = 0; k < NREQ; k++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (i == ((32'(ptr_i) + k) % NREQ))) begin
          found      = 1'b1;
          grant_o[i] = 1'b1;
          idx_o      = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: clears all registers after reset, then
// round-robins writeback requesters onto we3/a3/wd3. Option macro: RF_WR_ARB_X0_DROP_EN.
module regfile_wr_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned NREQ           = 3,
  parameter int unsigned XLEN           = rv_pkg::XLEN,
  parameter int unsigned AW             = rv_pkg::REG_AW,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  regfile_wr_arbiter_if.slave  req,
  output logic                 rf_we3,
  output logic [AW-1:0]        rf_a3,
  output logic [XLEN-1:0]      rf_wd3,
  output logic                 clearing,
  output logic [2:0]           grant_idx
);

  localparam arb_state_e    RESET_STATE = CLEAR_ON_RESET ? ARB_CLEAR : ARB_RUN;
  localparam logic [AW-1:0] CLR_LAST    = AW'(NUM_REGS - 1);

  arb_state_e      state_q, state_d;
  logic [2:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      gidx_q, gidx_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]   a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic            we_q, we_d;
  logic            clr_q, clr_d;

  logic [NREQ-1:0] grant;
  logic [2:0]      grant_i;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            fwd;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_i)
  );

  assign req.req_ready = (state_q == ARB_RUN) ? grant : '0;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_addr = req.req_addr[i*AW +: AW];
        sel_data = req.req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gidx_d    = gidx_q;
    clr_cnt_d = clr_cnt_q;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    we_d      = 1'b0;
    clr_d     = (state_q == ARB_CLEAR);
    fwd       = 1'b1;
    case (state_q)
      ARB_CLEAR: begin
        we_d  = 1'b1;
        a3_d  = clr_cnt_q;
        wd3_d = '0;
        if (clr_cnt_q == CLR_LAST) state_d = ARB_RUN;
        else                       clr_cnt_d = clr_cnt_q + AW'(1);
      end
      ARB_RUN: begin
        if (|grant) begin
          gidx_d   = grant_i;
          rr_ptr_d = (grant_i == 3'(NREQ - 1)) ? 3'd0 : grant_i + 3'd1;
`ifdef RF_WR_ARB_X0_DROP_EN
          fwd = (sel_addr != '0);
`endif
          // a3/wd3 only move on a forwarded write so an idle bus keeps its last value.
          if (fwd) begin
            we_d  = 1'b1;
            a3_d  = sel_addr;
            wd3_d = sel_data;
          end
        end
      end
      default: state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RESET_STATE;
      rr_ptr_q  <= '0;
      gidx_q    <= '0;
      clr_cnt_q <= '0;
      a3_q      <= '0;
      wd3_q     <= '0;
      we_q      <= 1'b0;
      clr_q     <= CLEAR_ON_RESET;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gidx_q    <= gidx_d;
      clr_cnt_q <= clr_cnt_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      we_q      <= we_d;
      clr_q     <= clr_d;
    end
  end

  assign rf_we3    = we_q;
  assign rf_a3     = a3_q;
  assign rf_wd3    = wd3_q;
  assign clearing  = clr_q;
  assign grant_idx = gidx_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: clear pass, round-robin order,
// single-requester latency, x0 handling and mid-operation reset.
module tb_regfile_wr_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk;
  logic            resetn;
  logic            rf_we3;
  logic [AW-1:0]   rf_a3;
  logic [XLEN-1:0] rf_wd3;
  logic            clearing;
  logic [2:0]      grant_idx;

  int unsigned tests;
  int unsigned fails;

  regfile_wr_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) bus ();

  regfile_wr_arbiter #(
    .NREQ           (NREQ),
    .XLEN           (XLEN),
    .AW             (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (bus.slave),
    .rf_we3    (rf_we3),
    .rf_a3     (rf_a3),
    .rf_wd3    (rf_wd3),
    .clearing  (clearing),
    .grant_idx (grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Sample registered outputs 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.req_addr[i*AW +: AW]     = a;
    bus.req_data[i*XLEN +: XLEN] = d;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3",      32'(rf_we3),        32'd0);
    chk("rst_a3",       32'(rf_a3),         32'd0);
    chk("rst_wd3",      rf_wd3,             32'd0);
    chk("rst_ready",    32'(bus.req_ready), 32'd0);
    chk("rst_gidx",     32'(grant_idx),     32'd0);
    chk("rst_clearing", 32'(clearing),      32'd1);

    // Req 1 waits through the clear pass.
    set_req(1, 5'd9, 32'h0000_0099);
    bus.req_valid = 3'b010;
    resetn = 1'b1;

    for (int k = 0; k < 32; k++) begin
      tick();
      chk("clr_we3",      32'(rf_we3),   32'd1);
      chk("clr_a3",       32'(rf_a3),    32'(k));
      chk("clr_wd3",      rf_wd3,        32'd0);
      chk("clr_clearing", 32'(clearing), 32'd1);
      if (k < 31) chk("clr_ready", 32'(bus.req_ready), 32'd0);
    end
    chk("run1_ready", 32'(bus.req_ready), 32'b010);

    tick();
    bus.req_valid = '0;
    chk("run1_we3",      32'(rf_we3),    32'd1);
    chk("run1_a3",       32'(rf_a3),     32'd9);
    chk("run1_wd3",      rf_wd3,         32'h0000_0099);
    chk("run1_gidx",     32'(grant_idx), 32'd1);
    chk("run1_clearing", 32'(clearing),  32'd0);

    // Only req 2 valid; pointer is at 2 after the grant to 1.
    set_req(2, 5'd6, 32'hDEAD_BEEF);
    bus.req_valid = 3'b100;
    #1;
    chk("solo_ready", 32'(bus.req_ready), 32'b100);
    tick();
    bus.req_valid = '0;
    chk("solo_we3",  32'(rf_we3),    32'd1);
    chk("solo_a3",   32'(rf_a3),     32'd6);
    chk("solo_wd3",  rf_wd3,         32'hDEAD_BEEF);
    chk("solo_gidx", 32'(grant_idx), 32'd2);

    // All valid for 6 cycles from pointer 0: grants 0,1,2,0,1,2.
    set_req(0, 5'd5, 32'h0000_00A0);
    set_req(1, 5'd6, 32'h0000_00A1);
    set_req(2, 5'd7, 32'h0000_00A2);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 3)));
      tick();
      if (c == 5) bus.req_valid = '0;
      chk("rr_we3",  32'(rf_we3),    32'd1);
      chk("rr_a3",   32'(rf_a3),     32'(5 + (c % 3)));
      chk("rr_wd3",  rf_wd3,         32'(32'hA0 + (c % 3)));
      chk("rr_gidx", 32'(grant_idx), 32'(c % 3));
    end
    tick();
    chk("idle_we3", 32'(rf_we3), 32'd0);
    chk("idle_a3",  32'(rf_a3),  32'd7);
    chk("idle_wd3", rf_wd3,      32'h0000_00A2);

    // x0 write from req 0.
    set_req(0, 5'd0, 32'h0000_0055);
    bus.req_valid = 3'b001;
    #1;
    chk("x0_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = '0;
    chk("x0_gidx", 32'(grant_idx), 32'd0);
`ifdef RF_WR_ARB_X0_DROP_EN
    chk("x0_we3", 32'(rf_we3), 32'd0);
    chk("x0_a3",  32'(rf_a3),  32'd7);
`else
    chk("x0_we3", 32'(rf_we3), 32'd1);
    chk("x0_a3",  32'(rf_a3),  32'd0);
    chk("x0_wd3", rf_wd3,      32'h0000_0055);
`endif
    // Pointer must now be 1 in both builds.
    set_req(0, 5'd5, 32'h0000_00A0);
    bus.req_valid = 3'b111;
    #1;
    chk("ptr_ready", 32'(bus.req_ready), 32'b010);
    tick();
    bus.req_valid = '0;
    chk("ptr_a3", 32'(rf_a3), 32'd6);

    // Write in flight on rf_* when reset is pulsed.
    set_req(0, 5'd12, 32'h0000_0077);
    bus.req_valid = 3'b001;
    #1;
    chk("fl_ready", 32'(bus.req_ready), 32'b001);
    tick();
    bus.req_valid = '0;
    chk("fl_we3", 32'(rf_we3), 32'd1);
    chk("fl_a3",  32'(rf_a3),  32'd12);
    resetn = 1'b0;
    #1;
    chk("ar_we3",      32'(rf_we3),    32'd0);
    chk("ar_a3",       32'(rf_a3),     32'd0);
    chk("ar_wd3",      rf_wd3,         32'd0);
    chk("ar_gidx",     32'(grant_idx), 32'd0);
    chk("ar_clearing", 32'(clearing),  32'd1);
    #2;
    resetn = 1'b1;
    tick();
    chk("rc_we3", 32'(rf_we3),   32'd1);
    chk("rc_a3",  32'(rf_a3),    32'd0);
    chk("rc_wd3", rf_wd3,        32'd0);
    tick();
    chk("rc_a3b", 32'(rf_a3),    32'd1);
    chk("rc_clr", 32'(clearing), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
